// File: rtl/imem_responder.sv
// Instruction-memory responder: a word-addressed program store that answers one fetch
// at a time after a fixed LATENCY. It also accepts program-load writes in every state.
package sp_pkg;
    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 32;
endpackage

module imem_responder #(
    parameter int ADDR_WIDTH = sp_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = sp_pkg::DATA_WIDTH,
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 1
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic                  imem_req_i,
    input  logic [ADDR_WIDTH-1:0] imem_addr_i,
    output logic                  imem_ack_o,
    output logic [DATA_WIDTH-1:0] imem_rdata_o,
    output logic                  imem_err_o,
    output logic                  busy_o,
    input  logic                  load_en_i,
    input  logic [ADDR_WIDTH-1:0] load_addr_i,
    input  logic [DATA_WIDTH-1:0] load_data_i
);

    localparam int MEM_AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_W = ADDR_WIDTH'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  rd_ok;

    // PC steps by 2, so bit 0 must be clear and the word index is addr >> 1.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return !a[0] && ({1'b0, a[ADDR_WIDTH-1:1]} < DEPTH_W);
    endfunction

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: begin
                if (imem_req_i) begin
                    addr_d = imem_addr_i;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Unregistered read: a load landing during WAIT is seen in RESP, while a load in
    // the RESP cycle itself only commits at the closing edge.
    always_ff @(posedge clk_i) begin
        if (!srst_i && load_en_i && addr_ok(load_addr_i)) begin
            mem_q[load_addr_i[MEM_AW:1]] <= load_data_i;
        end
    end

    always_comb begin
        rd_ok        = addr_ok(addr_q);
        imem_ack_o   = (state_q == RESP);
        imem_err_o   = imem_ack_o && !rd_ok;
        imem_rdata_o = (imem_ack_o && rd_ok) ? mem_q[addr_q[MEM_AW:1]] : '0;
        busy_o       = (state_q == WAIT) || (state_q == RESP);
    end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: four instances (LATENCY 1..4) share one input stream and
// are tracked by a cycle-count reference model; table rows and sequences add fixed checks.
module tb_imem_responder;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int NI    = 4;

    logic          clk = 1'b0;
    logic          srst;
    logic          req;
    logic [AW-1:0] addr;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic [NI-1:0] ack, err, busy;
    logic [DW-1:0] rdata [NI];

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        imem_responder #(
            .ADDR_WIDTH(AW),
            .DATA_WIDTH(DW),
            .DEPTH     (DEPTH),
            .LATENCY   (g + 1)
        ) u_dut (
            .clk_i       (clk),
            .srst_i      (srst),
            .imem_req_i  (req),
            .imem_addr_i (addr),
            .imem_ack_o  (ack[g]),
            .imem_rdata_o(rdata[g]),
            .imem_err_o  (err[g]),
            .busy_o      (busy[g]),
            .load_en_i   (load_en),
            .load_addr_i (load_addr),
            .load_data_i (load_data)
        );
    end

    // Reference model: per instance, edges elapsed since capture (0 = no request).
    int            m_age  [NI];
    logic [AW-1:0] m_addr [NI];
    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_def  [DEPTH];

    function automatic bit legal(input logic [AW-1:0] a);
        return (a % 2 == 0) && ((a / 2) < DEPTH);
    endfunction

    task automatic chk(input string name, input int k, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s lat=%0d t=%0t got=%h want=%h", name, k + 1, $time, act, exp);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < NI; k++) begin
            if (srst) m_age[k] = 0;
            else if (m_age[k] == 0) begin
                if (req) begin
                    m_age[k]  = 1;
                    m_addr[k] = addr;
                end
            end else if (m_age[k] == k + 1) m_age[k] = 0;
            else m_age[k] = m_age[k] + 1;
        end
        if (!srst && load_en && legal(load_addr)) begin
            m_mem[load_addr / 2] = load_data;
            m_def[load_addr / 2] = 1'b1;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            bit            e_ack, ok;
            logic [DW-1:0] e_rd;
            e_ack = (m_age[k] == k + 1);
            ok    = legal(m_addr[k]);
            e_rd  = (e_ack && ok) ? m_mem[m_addr[k] / 2] : '0;
            chk("m_ack", k, DW'(ack[k]), DW'(e_ack));
            chk("m_err", k, DW'(err[k]), DW'(e_ack && !ok));
            chk("m_busy", k, DW'(busy[k]), DW'(m_age[k] != 0));
            if (!(e_ack && ok && !m_def[m_addr[k] / 2])) chk("m_rdata", k, rdata[k], e_rd);
        end
    endtask

    // One clock: the DUT and the model both take the edge, outputs checked 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic set_in(input bit r, input bit q, input logic [AW-1:0] a, input bit l,
                          input logic [AW-1:0] la, input logic [DW-1:0] ld);
        srst = r; req = q; addr = a; load_en = l; load_addr = la; load_data = ld;
    endtask

    task automatic chk_out(input string name, input int k, input bit e_ack, input bit e_err,
                           input bit e_busy, input logic [DW-1:0] e_rd);
        chk({name, "_ack"}, k, DW'(ack[k]), DW'(e_ack));
        chk({name, "_err"}, k, DW'(err[k]), DW'(e_err));
        chk({name, "_busy"}, k, DW'(busy[k]), DW'(e_busy));
        chk({name, "_rdata"}, k, rdata[k], e_rd);
    endtask

    typedef struct {
        bit            rst;
        bit            req;
        logic [AW-1:0] addr;
        bit            ld;
        logic [AW-1:0] la;
        logic [DW-1:0] ldd;
        bit            e_ack;
        bit            e_err;
        bit            e_busy;
        logic [DW-1:0] e_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic void v(input bit r, input bit q, input int a, input bit l, input int la,
                              input int ld, input bit ea, input bit ee, input bit eb, input int er);
        vec_t t;
        t.rst = r; t.req = q; t.addr = AW'(a); t.ld = l; t.la = AW'(la); t.ldd = DW'(ld);
        t.e_ack = ea; t.e_err = ee; t.e_busy = eb; t.e_rd = DW'(er);
        vecs.push_back(t);
    endfunction

    initial begin
        for (int i = 0; i < NI; i++) begin m_age[i] = 0; m_addr[i] = '0; end
        for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_def[i] = 1'b0; end
        set_in(1, 0, 0, 0, 0, 0);

        // Rows apply one cycle each; expectations are for the LATENCY=1 instance.
        v(1, 0, 0,   0, 0,   0,       0, 0, 0, 0);
        v(0, 0, 0,   1, 0,   'h11,    0, 0, 0, 0);
        v(0, 0, 0,   1, 2,   'h22,    0, 0, 0, 0);
        v(0, 0, 0,   1, 4,   'h33,    0, 0, 0, 0);
        v(0, 0, 0,   1, 6,   'h44,    0, 0, 0, 0);
        v(0, 1, 4,   0, 0,   0,       1, 0, 1, 'h33);
        v(0, 1, 0,   0, 0,   0,       0, 0, 0, 0);
        v(0, 1, 0,   0, 0,   0,       1, 0, 1, 'h11);
        v(0, 1, 0,   0, 0,   0,       0, 0, 0, 0);
        v(0, 1, 0,   0, 0,   0,       1, 0, 1, 'h11);
        v(0, 0, 0,   0, 0,   0,       0, 0, 0, 0);
        v(0, 1, 6,   0, 0,   0,       1, 0, 1, 'h44);
        v(0, 0, 0,   1, 6,   'h77,    0, 0, 0, 0);
        v(0, 1, 6,   0, 0,   0,       1, 0, 1, 'h77);
        v(0, 0, 0,   0, 0,   0,       0, 0, 0, 0);
        v(0, 1, 3,   0, 0,   0,       1, 1, 1, 0);
        v(0, 0, 0,   1, 3,   'hdead,  0, 0, 0, 0);
        v(0, 1, 128, 0, 0,   0,       1, 1, 1, 0);
        v(0, 0, 0,   1, 128, 'hbeef,  0, 0, 0, 0);
        v(0, 1, 2,   0, 0,   0,       1, 0, 1, 'h22);
        v(0, 0, 0,   0, 0,   0,       0, 0, 0, 0);
        v(0, 1, 0,   0, 0,   0,       1, 0, 1, 'h11);
        v(1, 1, 0,   1, 0,   'h55,    0, 0, 0, 0);
        v(0, 1, 0,   0, 0,   0,       1, 0, 1, 'h11);
        v(0, 0, 0,   0, 0,   0,       0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            set_in(vecs[i].rst, vecs[i].req, vecs[i].addr, vecs[i].ld, vecs[i].la, vecs[i].ldd);
            tick();
            chk_out($sformatf("vec%0d", i), 0, vecs[i].e_ack, vecs[i].e_err, vecs[i].e_busy,
                    vecs[i].e_rd);
        end

        // LATENCY=4: busy for four edges, ack only on the fourth; WAIT-time inputs ignored.
        set_in(1, 0, 0, 0, 0, 0); tick();
        set_in(0, 1, 2, 0, 0, 0); tick();
        chk_out("l4_c1", 3, 0, 0, 1, 0);
        set_in(0, 1, 6, 0, 0, 0); tick();
        chk_out("l4_c2", 3, 0, 0, 1, 0);
        set_in(0, 1, 4, 0, 0, 0); tick();
        chk_out("l4_c3", 3, 0, 0, 1, 0);
        set_in(0, 0, 0, 0, 0, 0); tick();
        chk_out("l4_c4", 3, 1, 0, 1, 'h22);
        tick();
        chk_out("l4_c5", 3, 0, 0, 0, 0);

        // LATENCY=3: reset one cycle after capture aborts the fetch.
        set_in(1, 0, 0, 0, 0, 0); tick();
        set_in(0, 1, 0, 0, 0, 0); tick();
        set_in(1, 0, 0, 0, 0, 0); tick();
        chk_out("l3_rst", 2, 0, 0, 0, 0);
        set_in(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("l3_noack", 2, 0, 0, 0, 0);
        end
        set_in(0, 1, 4, 0, 0, 0); tick();
        chk_out("l3_c1", 2, 0, 0, 1, 0);
        set_in(0, 0, 0, 0, 0, 0); tick();
        chk_out("l3_c2", 2, 0, 0, 1, 0);
        tick();
        chk_out("l3_c3", 2, 1, 0, 1, 'h33);

        // LATENCY=2: load to the captured word during WAIT shows up in the ack.
        set_in(1, 0, 0, 0, 0, 0); tick();
        set_in(0, 1, 6, 0, 0, 0); tick();
        chk_out("l2_wait", 1, 0, 0, 1, 0);
        set_in(0, 0, 0, 1, 6, 'h99); tick();
        chk_out("l2_resp", 1, 1, 0, 1, 'h99);

        // Fill the whole array, then free-running random traffic against the model.
        set_in(0, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < DEPTH; i++) begin
            set_in(0, 0, 0, 1, AW'(2 * i), DW'($urandom)); tick();
        end
        for (int n = 0; n < 1500; n++) begin
            int            sel;
            logic [AW-1:0] ra, la;
            sel = $urandom_range(0, 9);
            if (sel < 7) ra = AW'(2 * $urandom_range(0, DEPTH - 1));
            else if (sel == 7) ra = AW'(2 * $urandom_range(0, DEPTH - 1) + 1);
            else if (sel == 8) ra = AW'(2 * $urandom_range(DEPTH, 32767));
            else ra = AW'($urandom);
            la = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'(2 * $urandom_range(0, DEPTH - 1));
            set_in($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0, ra,
                   $urandom_range(0, 3) == 0, la, DW'($urandom));
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
